// File: rtl/uart_rx_cfg.sv
// Oversampled UART receiver with configurable framing, parity and stop bits,
// feeding a small circular FIFO that tags each entry with framing/parity errors.
module uart_rx_cfg #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          baud_tick,
    input  logic                          rx,
    input  logic                          rd_en,
    input  logic                          ovr_clr,
    output logic [DATA_BITS-1:0]          rd_data,
    output logic                          rd_frame_err,
    output logic                          rd_parity_err,
    output logic                          rd_valid,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overrun
);

    localparam int CTR_W   = $clog2(OVERSAMPLE);
    localparam int BIT_W   = $clog2(DATA_BITS);
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int ENTRY_W = DATA_BITS + 2;

    localparam logic [CTR_W-1:0] CTR_HALF   = CTR_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CTR_W-1:0] CTR_FULL   = CTR_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0] LAST_BIT   = BIT_W'(DATA_BITS - 1);
    localparam logic             LAST_STOP  = (STOP_BITS == 2);
    localparam logic             PARITY_ODD = (PARITY == 2);
    localparam logic [PTR_W:0]   LEVEL_FULL = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_PARITY    = 3'd3,
        S_STOP      = 3'd4,
        S_WAIT_HIGH = 3'd5
    } state_t;

    logic                 rx_meta_reg;
    logic                 rx_s_reg;
    state_t               state_reg;
    logic [CTR_W-1:0]     ctr_reg;
    logic [BIT_W-1:0]     bit_idx_reg;
    logic                 stop_idx_reg;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 frame_err_reg;
    logic                 parity_err_reg;

    logic                 stop_frame_err;
    logic                 push;
    logic [ENTRY_W-1:0]   push_entry;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_reg <= 1'b1;
            rx_s_reg    <= 1'b1;
        end else begin
            rx_meta_reg <= rx;
            rx_s_reg    <= rx_meta_reg;
        end
    end

    // Frame error as it will be after the current stop sample is taken.
    assign stop_frame_err = frame_err_reg | ~rx_s_reg;
    assign push = baud_tick && (state_reg == S_STOP) && (ctr_reg == CTR_FULL)
                  && (stop_idx_reg == LAST_STOP);
    assign push_entry = {shift_reg, stop_frame_err, parity_err_reg};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= S_IDLE;
            ctr_reg        <= '0;
            bit_idx_reg    <= '0;
            stop_idx_reg   <= 1'b0;
            shift_reg      <= '0;
            frame_err_reg  <= 1'b0;
            parity_err_reg <= 1'b0;
        end else if (baud_tick) begin
            case (state_reg)
                S_IDLE: begin
                    ctr_reg <= '0;
                    if (!rx_s_reg) state_reg <= S_START;
                end
                S_START: begin
                    if (ctr_reg == CTR_HALF) begin
                        ctr_reg        <= '0;
                        bit_idx_reg    <= '0;
                        stop_idx_reg   <= 1'b0;
                        frame_err_reg  <= 1'b0;
                        parity_err_reg <= 1'b0;
                        state_reg      <= rx_s_reg ? S_IDLE : S_DATA;
                    end else begin
                        ctr_reg <= ctr_reg + 1'b1;
                    end
                end
                S_DATA: begin
                    if (ctr_reg == CTR_FULL) begin
                        ctr_reg   <= '0;
                        shift_reg <= {rx_s_reg, shift_reg[DATA_BITS-1:1]};
                        if (bit_idx_reg == LAST_BIT)
                            state_reg <= (PARITY != 0) ? S_PARITY : S_STOP;
                        else
                            bit_idx_reg <= bit_idx_reg + 1'b1;
                    end else begin
                        ctr_reg <= ctr_reg + 1'b1;
                    end
                end
                S_PARITY: begin
                    if (ctr_reg == CTR_FULL) begin
                        ctr_reg        <= '0;
                        parity_err_reg <= ((^shift_reg) ^ rx_s_reg) != PARITY_ODD;
                        state_reg      <= S_STOP;
                    end else begin
                        ctr_reg <= ctr_reg + 1'b1;
                    end
                end
                S_STOP: begin
                    if (ctr_reg == CTR_FULL) begin
                        ctr_reg       <= '0;
                        frame_err_reg <= stop_frame_err;
                        if (stop_idx_reg == LAST_STOP)
                            state_reg <= stop_frame_err ? S_WAIT_HIGH : S_IDLE;
                        else
                            stop_idx_reg <= 1'b1;
                    end else begin
                        ctr_reg <= ctr_reg + 1'b1;
                    end
                end
                S_WAIT_HIGH: begin
                    // A break holds the line low; one entry only, then wait for idle.
                    ctr_reg <= '0;
                    if (rx_s_reg) state_reg <= S_IDLE;
                end
                default: begin
                    state_reg <= S_IDLE;
                    ctr_reg   <= '0;
                end
            endcase
        end
    end

    logic [ENTRY_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_reg;
    logic [PTR_W-1:0]   rd_ptr_reg;
    logic [PTR_W:0]     level_reg;
    logic               overrun_reg;
    logic               fifo_full;
    logic               do_pop;
    logic               do_push;
    logic               drop;
    logic [ENTRY_W-1:0] head;

    assign fifo_full = (level_reg == LEVEL_FULL);
    assign rd_valid  = (level_reg != '0);
    assign do_pop    = rd_en && rd_valid;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the frame.
    assign do_push   = push && (!fifo_full || do_pop);
    assign drop      = push && fifo_full && !do_pop;

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_reg] <= push_entry;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            level_reg   <= '0;
            overrun_reg <= 1'b0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level_reg <= level_reg + 1'b1;
                2'b01:   level_reg <= level_reg - 1'b1;
                default: level_reg <= level_reg;
            endcase
            if (drop)
                overrun_reg <= 1'b1;
            else if (ovr_clr)
                overrun_reg <= 1'b0;
        end
    end

    assign head          = mem[rd_ptr_reg];
    assign rd_data       = rd_valid ? head[ENTRY_W-1:2] : '0;
    assign rd_frame_err  = rd_valid & head[1];
    assign rd_parity_err = rd_valid & head[0];
    assign fifo_level    = level_reg;
    assign overrun       = overrun_reg;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: a default instance and a 5-bit/even-parity/2-stop instance,
// checked against a frame-level model of the received FIFO contents.
module tb_uart_rx_cfg;

    localparam int TICK_DIV = 4;
    localparam int DB_A = 8, OS_A = 8,  PAR_A = 0, SB_A = 1, FD_A = 4;
    localparam int DB_B = 5, OS_B = 16, PAR_B = 1, SB_B = 2, FD_B = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic baud_tick = 1'b0;

    logic                    rx_a = 1'b1, rd_en_a = 1'b0, ovr_clr_a = 1'b0;
    logic [DB_A-1:0]         rd_data_a;
    logic                    rd_frame_err_a, rd_parity_err_a, rd_valid_a, overrun_a;
    logic [$clog2(FD_A):0]   fifo_level_a;

    logic                    rx_b = 1'b1, rd_en_b = 1'b0, ovr_clr_b = 1'b0;
    logic [DB_B-1:0]         rd_data_b;
    logic                    rd_frame_err_b, rd_parity_err_b, rd_valid_b, overrun_b;
    logic [$clog2(FD_B):0]   fifo_level_b;

    int checks = 0;
    int errors = 0;
    int q_a[$];
    int q_b[$];
    int ovr_a = 0;
    int ovr_b = 0;

    uart_rx_cfg #(.DATA_BITS(DB_A), .OVERSAMPLE(OS_A), .PARITY(PAR_A),
                  .STOP_BITS(SB_A), .FIFO_DEPTH(FD_A)) dut_a (
        .clk(clk), .rst(rst), .baud_tick(baud_tick), .rx(rx_a), .rd_en(rd_en_a),
        .ovr_clr(ovr_clr_a), .rd_data(rd_data_a), .rd_frame_err(rd_frame_err_a),
        .rd_parity_err(rd_parity_err_a), .rd_valid(rd_valid_a),
        .fifo_level(fifo_level_a), .overrun(overrun_a));

    uart_rx_cfg #(.DATA_BITS(DB_B), .OVERSAMPLE(OS_B), .PARITY(PAR_B),
                  .STOP_BITS(SB_B), .FIFO_DEPTH(FD_B)) dut_b (
        .clk(clk), .rst(rst), .baud_tick(baud_tick), .rx(rx_b), .rd_en(rd_en_b),
        .ovr_clr(ovr_clr_b), .rd_data(rd_data_b), .rd_frame_err(rd_frame_err_b),
        .rd_parity_err(rd_parity_err_b), .rd_valid(rd_valid_b),
        .fifo_level(fifo_level_b), .overrun(overrun_b));

    always #5 clk = ~clk;

    // One tick every TICK_DIV clocks, high across exactly one rising edge.
    initial begin
        forever begin
            repeat (TICK_DIV - 1) @(negedge clk);
            baud_tick = 1'b1;
            @(negedge clk);
            baud_tick = 1'b0;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: time limit reached, got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_ticks(input int n);
        repeat (n) begin
            do @(posedge clk); while (baud_tick !== 1'b1);
        end
        #1;
    endtask

    function automatic int os_of(input int d);
        return (d == 0) ? OS_A : OS_B;
    endfunction

    task automatic set_rx(input int d, input logic v);
        if (d == 0) rx_a = v; else rx_b = v;
    endtask

    task automatic set_rd_en(input int d, input logic v);
        if (d == 0) rd_en_a = v; else rd_en_b = v;
    endtask

    function automatic int get_level(input int d);
        return (d == 0) ? int'(fifo_level_a) : int'(fifo_level_b);
    endfunction

    function automatic int get_ovr(input int d);
        return (d == 0) ? int'(overrun_a) : int'(overrun_b);
    endfunction

    function automatic int q_size(input int d);
        return (d == 0) ? q_a.size() : q_b.size();
    endfunction

    // Model entry: data*4 + frame_err*2 + parity_err, derived from the frame content.
    function automatic int expect_entry(input int d, input int data, input int par_bit, input int stops);
        int db    = (d == 0) ? DB_A : DB_B;
        int par   = (d == 0) ? PAR_A : PAR_B;
        int sb    = (d == 0) ? SB_A : SB_B;
        int value = data % (1 << db);
        int fe    = 0;
        int pe    = 0;
        if (par != 0)
            pe = ((($countones(value) + par_bit) % 2) == ((par == 2) ? 1 : 0)) ? 0 : 1;
        for (int s = 0; s < sb; s++)
            if (((stops >> s) & 1) == 0) fe = 1;
        return value * 4 + fe * 2 + pe;
    endfunction

    task automatic model_push(input int d, input int e);
        if (d == 0) begin
            if (q_a.size() < FD_A) q_a.push_back(e); else ovr_a = 1;
        end else begin
            if (q_b.size() < FD_B) q_b.push_back(e); else ovr_b = 1;
        end
    endtask

    task automatic model_pop(input int d);
        if (d == 0) begin
            if (q_a.size() > 0) void'(q_a.pop_front());
        end else begin
            if (q_b.size() > 0) void'(q_b.pop_front());
        end
    endtask

    task automatic check_head(input int d, input string tag);
        int e;
        if (q_size(d) == 0) begin
            check_val({tag, " valid"}, (d == 0) ? rd_valid_a : rd_valid_b, 0);
        end else begin
            e = (d == 0) ? q_a[0] : q_b[0];
            check_val({tag, " valid"}, (d == 0) ? rd_valid_a : rd_valid_b, 1);
            check_val({tag, " data"}, (d == 0) ? 32'(rd_data_a) : 32'(rd_data_b), e / 4);
            check_val({tag, " frame_err"}, (d == 0) ? rd_frame_err_a : rd_frame_err_b, (e / 2) % 2);
            check_val({tag, " parity_err"}, (d == 0) ? rd_parity_err_a : rd_parity_err_b, e % 2);
        end
    endtask

    task automatic pop_check(input int d, input string tag);
        check_head(d, tag);
        set_rd_en(d, 1'b1);
        @(posedge clk);
        #1 set_rd_en(d, 1'b0);
        model_pop(d);
        check_val({tag, " level after pop"}, get_level(d), q_size(d));
        $display("pop  dut%0d %s: level now %0d", d, tag, get_level(d));
    endtask

    // Drives one frame bit by bit; optionally raises rd_en exactly on the push cycle.
    task automatic send_frame(input int d, input int data, input int par_bit, input int stops,
                              input bit pop_on_push, input string tag);
        int os  = os_of(d);
        int db  = (d == 0) ? DB_A : DB_B;
        int par = (d == 0) ? PAR_A : PAR_B;
        int sb  = (d == 0) ? SB_A : SB_B;
        int e   = expect_entry(d, data, par_bit, stops);
        wait_ticks(1);
        set_rx(d, 1'b0);
        wait_ticks(os);
        for (int i = 0; i < db; i++) begin
            set_rx(d, ((data >> i) & 1) != 0);
            wait_ticks(os);
        end
        if (par != 0) begin
            set_rx(d, par_bit != 0);
            wait_ticks(os);
        end
        for (int s = 0; s < sb; s++) begin
            set_rx(d, ((stops >> s) & 1) != 0);
            if (s < sb - 1) wait_ticks(os);
        end
        wait_ticks(os / 2);
        if (pop_on_push) begin
            repeat (TICK_DIV - 1) @(posedge clk);
            #1 set_rd_en(d, 1'b1);
            check_head(d, {tag, " head@push"});
            @(posedge clk);
            #1 set_rd_en(d, 1'b0);
            model_pop(d);
        end else begin
            wait_ticks(1);
        end
        model_push(d, e);
        check_val({tag, " level"}, get_level(d), q_size(d));
        check_val({tag, " overrun"}, get_ovr(d), (d == 0) ? ovr_a : ovr_b);
        $display("frame dut%0d %s: data=0x%0h level=%0d overrun=%0d", d, tag, data,
                 get_level(d), get_ovr(d));
        wait_ticks(os / 2 - 1);
        set_rx(d, 1'b1);
        wait_ticks(2 * os);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, " a level"}, fifo_level_a, 0);
        check_val({tag, " a valid"}, rd_valid_a, 0);
        check_val({tag, " a data"}, rd_data_a, 0);
        check_val({tag, " a flags"}, {rd_frame_err_a, rd_parity_err_a, overrun_a}, 0);
        check_val({tag, " b level"}, fifo_level_b, 0);
        check_val({tag, " b valid"}, rd_valid_b, 0);
        check_val({tag, " b data"}, rd_data_b, 0);
        check_val({tag, " b flags"}, {rd_frame_err_b, rd_parity_err_b, overrun_b}, 0);
    endtask

    initial begin
        int d, data, pb, stops;
        bit pop_on;

        #1 rst = 1'b1;
        #2 check_reset_outputs("reset");
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Default frame 0xA5.
        send_frame(0, 8'hA5, 0, 1, 1'b0, "a5");
        pop_check(0, "a5");

        // Two-tick glitch is a false start; a later frame still decodes.
        wait_ticks(1);
        rx_a = 1'b0;
        wait_ticks(2);
        rx_a = 1'b1;
        wait_ticks(3 * OS_A);
        check_val("glitch level", fifo_level_a, 0);
        check_val("glitch valid", rd_valid_a, 0);
        send_frame(0, 8'h3C, 0, 1, 1'b0, "after_glitch");
        pop_check(0, "after_glitch");

        // Break: 20 bit periods low gives a single 0x00 entry with frame error.
        wait_ticks(1);
        rx_a = 1'b0;
        wait_ticks(20 * OS_A);
        model_push(0, expect_entry(0, 0, 0, 0));
        check_val("break level low", fifo_level_a, 1);
        rx_a = 1'b1;
        wait_ticks(3 * OS_A);
        check_val("break level high", fifo_level_a, 1);
        pop_check(0, "break");

        // Overflow with no reads.
        for (int i = 1; i <= 5; i++) send_frame(0, i, 0, 1, 1'b0, "fill");
        check_val("ovf level", fifo_level_a, FD_A);
        check_val("ovf overrun", overrun_a, 1);
        for (int i = 0; i < 4; i++) pop_check(0, "ovf pop");
        ovr_clr_a = 1'b1;
        @(posedge clk);
        #1 ovr_clr_a = 1'b0;
        ovr_a = 0;
        check_val("ovr_clr", overrun_a, 0);

        // Drop while ovr_clr is held: the drop wins on that edge.
        for (int i = 0; i < 4; i++) send_frame(0, 8'h11 + i, 0, 1, 1'b0, "refill");
        ovr_clr_a = 1'b1;
        send_frame(0, 8'h55, 0, 1, 1'b0, "drop_clr");
        check_val("drop_clr later", overrun_a, 0);
        ovr_clr_a = 1'b0;
        ovr_a = 0;

        // Push on a full FIFO with a pop in the same cycle.
        send_frame(0, 8'h66, 0, 1, 1'b1, "push_pop_full");
        check_val("push_pop_full overrun", overrun_a, 0);
        for (int i = 0; i < 4; i++) pop_check(0, "pp pop");
        pop_check(0, "empty pop");

        // Parity and double stop bit on the 5-bit instance.
        send_frame(1, 8'h07, 1, 3, 1'b0, "par_ok");
        pop_check(1, "par_ok");
        send_frame(1, 8'h07, 0, 3, 1'b0, "par_bad");
        pop_check(1, "par_bad");
        send_frame(1, 8'h15, 1, 1, 1'b0, "stop2_low");
        pop_check(1, "stop2_low");

        // Randomized frames on both instances.
        for (int n = 0; n < 30; n++) begin
            d      = $urandom_range(0, 1);
            data   = $urandom_range(0, 255);
            pb     = $urandom_range(0, 1);
            stops  = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 3) : 3;
            pop_on = ($urandom_range(0, 3) == 0);
            send_frame(d, data, pb, stops, pop_on, "rand");
            if ($urandom_range(0, 2) == 0) pop_check(d, "rand");
        end
        check_val("rand ovr a", overrun_a, ovr_a);
        check_val("rand ovr b", overrun_b, ovr_b);
        while (q_a.size() > 0) pop_check(0, "drain");
        while (q_b.size() > 0) pop_check(1, "drain");

        // Reset mid-frame on b while a holds an entry.
        send_frame(0, 8'h5A, 0, 1, 1'b0, "pre_rst");
        wait_ticks(1);
        rx_b = 1'b0;
        wait_ticks(3 * OS_B);
        @(posedge clk);
        #2 rst = 1'b1;
        #1 check_reset_outputs("midrst");
        rx_b = 1'b1;
        q_a.delete();
        q_b.delete();
        ovr_a = 0;
        ovr_b = 0;
        repeat (4) @(posedge clk);
        #1 rst = 1'b0;
        wait_ticks(12 * OS_B);
        check_val("post_rst b level", fifo_level_b, 0);
        check_val("post_rst b valid", rd_valid_b, 0);
        check_val("post_rst a level", fifo_level_a, 0);
        send_frame(1, 8'h0B, 1, 3, 1'b0, "post_rst");
        pop_check(1, "post_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
